// File: rtl/led_pkg.sv
// Shared types and constants for the LED step generator and its key conditioner.
package led_pkg;

    typedef logic [1:0] speed_t;

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } state_t;

    localparam int NUM_SPEEDS = 4;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_cond.sv
// Key conditioner: 2-FF synchronizer, optional debounce (LED_STEP_DEBOUNCE_EN), press-edge detect.
module key_cond
    import led_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic prev_q;

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("key_cond: DEB_CYCLES must be at least 1");
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= i_key_n;
            sync2_q <= sync1_q;
            prev_q  <= level;
        end
    end

`ifdef LED_STEP_DEBOUNCE_EN
    localparam int DW = cnt_w(DEB_CYCLES);

    logic [DW-1:0] deb_cnt_q;
    logic [DW-1:0] deb_cnt_d;
    logic          deb_lvl_q;
    logic          deb_lvl_d;

    // Counter only advances while the synchronized key disagrees with the accepted level.
    always_comb begin
        deb_cnt_d = '0;
        deb_lvl_d = deb_lvl_q;
        if (sync2_q != deb_lvl_q) begin
            if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
                deb_lvl_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            deb_cnt_q <= '0;
            deb_lvl_q <= 1'b1;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            deb_lvl_q <= deb_lvl_d;
        end
    end

    assign level = deb_lvl_q;
`else
    assign level = sync2_q;
`endif

    assign o_press = prev_q & ~level;

endmodule

// File: rtl/led_step_gen.sv
// LED step/direction strobe generator with speed and run/pause keys.
// Key debouncing is compiled in when LED_STEP_DEBOUNCE_EN is defined.
module led_step_gen
    import led_pkg::*;
#(
    parameter int BASE_DIV      = 5_000_000,
    parameter int STEPS_PER_DIR = 7,
    parameter int DEB_CYCLES    = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_speed_n,
    input  logic       i_key_pause_n,
    output logic       o_next_led,
    output logic       o_tick,
    output logic [1:0] o_speed,
    output logic       o_running
);

    localparam int PW = cnt_w(BASE_DIV);
    localparam int SW = cnt_w(STEPS_PER_DIR);

    localparam logic [0:0] S_RUN   = RUN;
    localparam logic [0:0] S_PAUSE = PAUSE;

    logic          speed_press;
    logic          pause_press;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] step_q, step_d;
    speed_t        speed_q, speed_d;
    logic [0:0]    state_q, state_d;
    logic          next_led_q, next_led_d;
    logic          tick_q, tick_d;
    logic [31:0]   div_raw;
    logic [PW-1:0] div_last;

    if (STEPS_PER_DIR < 1) begin : g_bad_steps
        $error("led_step_gen: STEPS_PER_DIR must be at least 1");
    end

    key_cond #(.DEB_CYCLES(DEB_CYCLES)) u_key_speed (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key_n (i_key_speed_n),
        .o_press (speed_press)
    );

    key_cond #(.DEB_CYCLES(DEB_CYCLES)) u_key_pause (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key_n (i_key_pause_n),
        .o_press (pause_press)
    );

    // A divisor that shifts down to zero is treated as one (strobe every cycle).
    assign div_raw  = 32'(BASE_DIV) >> speed_q;
    assign div_last = (div_raw == 32'd0) ? '0 : PW'(div_raw - 32'd1);

    always_comb begin
        presc_d    = presc_q;
        step_d     = step_q;
        speed_d    = speed_q;
        state_d    = state_q;
        next_led_d = 1'b0;
        tick_d     = 1'b0;

        // A speed press pre-empts the terminal count: no strobe, step count untouched.
        if (speed_press) begin
            speed_d = speed_t'((int'(speed_q) + 1) % NUM_SPEEDS);
            presc_d = '0;
        end else if (state_q == S_RUN) begin
            if (presc_q == div_last) begin
                presc_d    = '0;
                next_led_d = 1'b1;
                if (step_q == SW'(STEPS_PER_DIR - 1)) begin
                    step_d = '0;
                    tick_d = 1'b1;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (pause_press) begin
            state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            presc_q    <= '0;
            step_q     <= '0;
            speed_q    <= '0;
            state_q    <= S_RUN;
            next_led_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            step_q     <= step_d;
            speed_q    <= speed_d;
            state_q    <= state_d;
            next_led_q <= next_led_d;
            tick_q     <= tick_d;
        end
    end

    assign o_next_led = next_led_q;
    assign o_tick     = tick_q;
    assign o_speed    = speed_q;
    assign o_running  = (state_q == S_RUN);

endmodule

// File: tb/tb_led_step_gen.sv
// Bench for led_step_gen: directed and random key/reset stimulus against a behavioural model.
module tb_led_step_gen;

    localparam int BD  = 8;
    localparam int SPD = 3;
    localparam int DEB = 4;
`ifdef LED_STEP_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif
    // Edges between the first sampled-low edge of a key and the edge its press acts on.
    localparam int KEY_LAT = 2 + (DEB_ON ? DEB : 0);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ks_n = 1'b1;
    logic       kp_n = 1'b1;
    logic       o_next_led;
    logic       o_tick;
    logic [1:0] o_speed;
    logic       o_running;

    always #5 clk = ~clk;

    led_step_gen #(.BASE_DIV(BD), .STEPS_PER_DIR(SPD), .DEB_CYCLES(DEB)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_key_speed_n (ks_n),
        .i_key_pause_n (kp_n),
        .o_next_led    (o_next_led),
        .o_tick        (o_tick),
        .o_speed       (o_speed),
        .o_running     (o_running)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    bit          m_run   = 1'b1;
    int          m_speed = 0;
    int          m_phase = 0;
    int          m_steps = 0;
    bit          m_led   = 1'b0;
    bit          m_tick  = 1'b0;
    logic [15:0] hist [2];     // raw key samples, bit0 = previous edge
    bit          lvl  [2];     // accepted key level after the previous edge
    bit          lvl2 [2];     // accepted key level two edges back

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit raw [2];
        bit press [2];
        bit all_new;
        int div;
        raw[0] = ks_n;
        raw[1] = kp_n;
        if (!rst_n) begin
            m_run = 1'b1; m_speed = 0; m_phase = 0; m_steps = 0;
            m_led = 1'b0; m_tick = 1'b0;
            for (int k = 0; k < 2; k++) begin
                hist[k] = '1; lvl[k] = 1'b1; lvl2[k] = 1'b1;
            end
            return;
        end
        for (int k = 0; k < 2; k++) press[k] = lvl2[k] & ~lvl[k];

        div = BD >> m_speed;
        if (div < 1) div = 1;
        m_led  = 1'b0;
        m_tick = 1'b0;
        if (press[0]) begin
            m_speed = (m_speed + 1) % 4;
            m_phase = 0;
        end else if (m_run) begin
            m_phase = m_phase + 1;
            if (m_phase == div) begin
                m_phase = 0;
                m_led   = 1'b1;
                m_steps = m_steps + 1;
                if (m_steps == SPD) begin
                    m_steps = 0;
                    m_tick  = 1'b1;
                end
            end
        end
        if (press[1]) m_run = !m_run;

        // Accepted level: synchronized key seen at this edge is the raw sample two edges back.
        for (int k = 0; k < 2; k++) begin
            bit nl;
            if (DEB_ON) begin
                nl = lvl[k];
                all_new = 1'b1;
                for (int i = 1; i <= DEB; i++) if (hist[k][i] == lvl[k]) all_new = 1'b0;
                if (all_new) nl = ~lvl[k];
            end else begin
                nl = hist[k][0];
            end
            lvl2[k] = lvl[k];
            lvl[k]  = nl;
            hist[k] = {hist[k][14:0], raw[k]};
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("next_led", 32'(o_next_led), 32'(m_led));
        check("tick",     32'(o_tick),     32'(m_tick));
        check("speed",    32'(o_speed),    32'(m_speed));
        check("running",  32'(o_running),  32'(m_run));
    endtask

    task automatic hold(input bit s, input bit p, input int n);
        ks_n = s;
        kp_n = p;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int n;
        int cnt;
        int sp0;
        int s_left;
        int p_left;
        bit run0;

        // Reset values
        hold(1, 1, 3);
        check("rst_speed",    32'(o_speed),    32'd0);
        check("rst_running",  32'(o_running),  32'd1);
        check("rst_next_led", 32'(o_next_led), 32'd0);
        check("rst_tick",     32'(o_tick),     32'd0);

        // Free run: strobe every BD edges, tick on the SPD-th strobe
        rst_n = 1'b1;
        n = 0; cnt = 0;
        do begin cyc(); n++; end while (!o_next_led && n < 50);
        check("first_strobe_cycle", n, BD);
        cnt = 1;
        while (!o_tick && n < 200) begin
            cyc(); n++;
            if (o_next_led) cnt++;
        end
        check("tick_cycle", n, BD * SPD);
        check("strobes_to_tick", cnt, SPD);

        // Four speed presses walk 1, 2, 3, 0
        for (int i = 1; i <= 4; i++) begin
            hold(0, 1, 6);
            hold(1, 1, 30);
            check("speed_walk", 32'(o_speed), 32'(i % 4));
        end

        // Pause mid-count, hold paused, resume
        n = 0;
        while (m_phase != ((5 - KEY_LAT) % BD + BD) % BD && n < 100) begin cyc(); n++; end
        check("reach_pause_point", 32'(n < 100), 32'd1);
        hold(1, 0, 6);
        hold(1, 1, 100);
        check("paused", 32'(o_running), 32'd0);
        hold(1, 0, 6);
        hold(1, 1, 20);
        check("resumed", 32'(o_running), 32'd1);

        // Short glitch on the speed key
        sp0 = o_speed;
        hold(0, 1, 3);
        hold(1, 1, 20);
        check("glitch_speed", 32'(o_speed), DEB_ON ? 32'(sp0) : 32'((sp0 + 1) % 4));

        // Back to speed 0, then land a speed press on the terminal count
        while (m_speed != 0) begin hold(0, 1, 6); hold(1, 1, 12); end
        n = 0;
        while (m_phase != ((BD - 1 - KEY_LAT) % BD + BD) % BD && n < 100) begin cyc(); n++; end
        check("reach_terminal_point", 32'(n < 100), 32'd1);
        hold(0, 1, 6);
        hold(1, 1, 20);

        // Both keys in one cycle
        sp0 = o_speed; run0 = o_running;
        hold(0, 0, 6);
        hold(1, 1, 20);
        check("both_speed", 32'(o_speed), 32'((sp0 + 1) % 4));
        check("both_running", 32'(o_running), 32'(!run0));

        // Random keys with occasional resets
        s_left = 5; p_left = 9;
        for (int i = 0; i < 3000; i++) begin
            if (--s_left <= 0) begin
                ks_n = ~ks_n;
                s_left = ks_n ? $urandom_range(1, 20) : $urandom_range(1, 8);
            end
            if (--p_left <= 0) begin
                kp_n = ~kp_n;
                p_left = kp_n ? $urandom_range(4, 40) : $urandom_range(1, 8);
            end
            rst_n = ($urandom_range(0, 299) != 0);
            cyc();
        end
        rst_n = 1'b1;

        // Reset mid-count at prescaler 6, step 2
        hold(1, 1, 12);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        n = 0;
        while (!(m_phase == 6 && m_steps == 2) && n < 100) begin cyc(); n++; end
        check("reach_reset_point", 32'(n < 100), 32'd1);
        rst_n = 1'b0;
        cyc();
        check("mid_rst_speed",   32'(o_speed),    32'd0);
        check("mid_rst_running", 32'(o_running),  32'd1);
        check("mid_rst_strobe",  32'(o_next_led), 32'd0);
        rst_n = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!o_next_led && n < 50);
        check("post_rst_first_strobe", n, BD);
        cnt = 1;
        while (!o_tick && n < 200) begin
            cyc(); n++;
            if (o_next_led) cnt++;
        end
        check("post_rst_strobes_to_tick", cnt, SPD);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/led_step_gen.md
LED_STEP_GEN -- requirements
Module: led_step_gen

Interface
REQ-001 SHALL have parameter BASE_DIV, 5_000_000, i_clk cycles per step at speed 0 (10 Hz at 50 MHz).
REQ-002 SHALL have parameter STEPS_PER_DIR, 7, steps between direction-toggle ticks; legal range is 1 or more.
REQ-003 SHALL have parameter DEB_CYCLES, 1_000_000, cycles a key must be stable to be accepted (20 ms).
REQ-004 SHALL have port i_clk, input, 1, system clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, reset; it is synchronous and active-low.
REQ-006 SHALL have port i_key_speed_n, input, 1, asynchronous active-low speed button.
REQ-007 SHALL have port i_key_pause_n, input, 1, asynchronous active-low run/pause button.
REQ-008 SHALL have port o_next_led, output, 1, one-cycle step strobe to the LED driver.
REQ-009 SHALL have port o_tick, output, 1, one-cycle direction-toggle strobe to the LED driver.
REQ-010 SHALL have port o_speed, output, 2, current speed level.
REQ-011 SHALL have port o_running, output, 1, high in RUN state.

Function
REQ-012 Each key SHALL pass through a 2-FF synchronizer before any other use.
REQ-013 A key press event SHALL be a one-cycle pulse on the high-to-low transition of the conditioned key (see Configuration).
REQ-014 Speed press SHALL increment o_speed modulo 4 (3 wraps to 0) and clear the prescaler in the same cycle.
REQ-015 Step divisor SHALL be BASE_DIV >> o_speed, evaluated combinationally from the registered o_speed.
REQ-016 FSM SHALL have states RUN and PAUSE; a pause press toggles RUN to PAUSE and PAUSE to RUN; no other transitions exist.
REQ-017 In RUN, the prescaler SHALL count 0 to divisor-1; at divisor-1 it returns to 0 and o_next_led is high for exactly that cycle.
REQ-018 In PAUSE, the prescaler and step counter SHALL hold, and o_next_led and o_tick SHALL be low.
REQ-019 The step counter SHALL increment on each o_next_led; on the pulse where it equals STEPS_PER_DIR-1 it wraps to 0 and o_tick is high in that same cycle.
REQ-020 o_tick SHALL never be high without o_next_led in the same cycle.
REQ-021 If a speed press and a terminal count coincide, the speed press SHALL win: no strobe, the prescaler is cleared, and the step counter is unchanged.
REQ-022 Simultaneous speed and pause presses SHALL both be applied in the same cycle.
REQ-023 A pause press on a terminal-count cycle in RUN SHALL still emit that strobe; PAUSE takes effect from the next cycle.
REQ-024 o_next_led and o_tick SHALL be registered outputs.

Reset
REQ-025 While i_rst_n=0 at a clock edge, the block SHALL set o_next_led=0, o_tick=0, o_speed=0, o_running=1 (RUN), prescaler=0, step counter=0, synchronizers=1, and debounce state to released.
REQ-026 Reset asserted mid-count SHALL discard all progress; the first strobe after release occurs BASE_DIV cycles after the first cycle with i_rst_n=1.

Configuration
REQ-027 Key debouncing SHALL be compiled in by macro LED_STEP_DEBOUNCE_EN.
REQ-028 With LED_STEP_DEBOUNCE_EN defined, a synchronized key SHALL change its conditioned level only after DEB_CYCLES consecutive cycles at the new value; the counter restarts on any bounce.
REQ-029 Without LED_STEP_DEBOUNCE_EN, the conditioned level SHALL equal the synchronized level, DEB_CYCLES SHALL be ignored, and no debounce counters SHALL exist.

Structure
REQ-030 Package led_pkg SHALL hold typedef speed_t (2-bit), enum state_t {RUN, PAUSE}, and constant NUM_SPEEDS=4.
REQ-031 Sub-module key_cond SHALL contain synchronizer, optional debounce, and press-edge detect, and SHALL be instantiated once per key.
REQ-032 Counter widths SHALL be $clog2 of BASE_DIV and of STEPS_PER_DIR, with a minimum of 1 bit each.

Verification (BASE_DIV=8, STEPS_PER_DIR=3, DEB_CYCLES=4)
REQ-033 Release reset, no keys -> o_next_led on cycles 8, 16, 24; o_tick only on cycle 24; o_speed=0; o_running=1.
REQ-034 Three speed presses -> o_speed 1, 2, 3, then wraps to 0 on a fourth press; strobe period becomes 4, 2, 1 cycles; prescaler is cleared at each press.
REQ-035 Pause press mid-count at prescaler=5 -> no strobes for 100 cycles; second press -> next strobe 2 cycles after resume, o_running follows.
REQ-036 With LED_STEP_DEBOUNCE_EN, a 3-cycle low glitch on i_key_speed_n -> no speed change; a 6-cycle low -> exactly one increment; without the macro, the glitch -> one increment.
REQ-037 Speed press on the terminal-count cycle -> no o_next_led that cycle, step count preserved; both keys in one cycle -> speed+1 and PAUSE.
REQ-038 Reset at prescaler=6, step=2 -> all outputs at reset values; first strobe 8 cycles after release; o_tick after 3 strobes.
